// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store address-generation queue.
// Contents: funct3 size codes, op-type constants, queue entry bookkeeping struct and
// the misalignment predicate used when LSU_MISALIGN_TRAP_EN is defined.
// Operand value/tag/ready state lives in agu_operand_slot instances, so the entry
// struct here only carries the fields that never change after dispatch.
package lsu_pkg;

  // funct3[1:0] access size, funct3[2] selects zero-extension on loads.
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam int unsigned MEM_U_BIT = 2;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } entry_meta_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes never fault.
  function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
    return ((funct3[1:0] == MEM_H) && addr_lo[0]) ||
           ((funct3[1:0] == MEM_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_agu_queue_if.sv
// Bundle of the dispatch, CDB and LSU-issue signals of lsu_agu_queue.
// Signal names keep the queue's point of view (_i into the queue, _o out of it).
//   slave  : the queue itself
//   master : the surrounding pipeline (dispatch, CDB, lsu)
// Optional: lsu_misalign_o exists only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_agu_queue_if #(
  parameter int unsigned TAG_W         = 4,
  parameter int unsigned DMEM_ADDR_LEN = 8
);

  logic                     disp_valid_i;
  logic                     disp_ready_o;
  logic                     disp_is_store_i;
  logic [2:0]               disp_funct3_i;
  logic [31:0]              disp_imm_i;
  logic [TAG_W-1:0]         disp_rd_tag_i;
  logic [31:0]              disp_rs1_val_i;
  logic [TAG_W-1:0]         disp_rs1_tag_i;
  logic                     disp_rs1_rdy_i;
  logic [31:0]              disp_rs2_val_i;
  logic [TAG_W-1:0]         disp_rs2_tag_i;
  logic                     disp_rs2_rdy_i;

  logic                     cdb_valid_i;
  logic [TAG_W-1:0]         cdb_tag_i;
  logic [31:0]              cdb_data_i;

  logic                     lsu_valid_o;
  logic                     lsu_ready_i;
  logic                     lsu_is_store_o;
  logic [2:0]               lsu_funct3_o;
  logic [DMEM_ADDR_LEN-1:0] lsu_addr_o;
  logic [31:0]              lsu_wdata_o;
  logic [TAG_W-1:0]         lsu_rd_tag_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                     lsu_misalign_o;
`endif

  modport slave (
`ifdef LSU_MISALIGN_TRAP_EN
    output lsu_misalign_o,
`endif
    input  disp_valid_i, disp_is_store_i, disp_funct3_i, disp_imm_i, disp_rd_tag_i,
    input  disp_rs1_val_i, disp_rs1_tag_i, disp_rs1_rdy_i,
    input  disp_rs2_val_i, disp_rs2_tag_i, disp_rs2_rdy_i,
    input  cdb_valid_i, cdb_tag_i, cdb_data_i,
    input  lsu_ready_i,
    output disp_ready_o,
    output lsu_valid_o, lsu_is_store_o, lsu_funct3_o, lsu_addr_o, lsu_wdata_o, lsu_rd_tag_o
  );

  modport master (
`ifdef LSU_MISALIGN_TRAP_EN
    input  lsu_misalign_o,
`endif
    output disp_valid_i, disp_is_store_i, disp_funct3_i, disp_imm_i, disp_rd_tag_i,
    output disp_rs1_val_i, disp_rs1_tag_i, disp_rs1_rdy_i,
    output disp_rs2_val_i, disp_rs2_tag_i, disp_rs2_rdy_i,
    output cdb_valid_i, cdb_tag_i, cdb_data_i,
    output lsu_ready_i,
    input  disp_ready_o,
    input  lsu_valid_o, lsu_is_store_o, lsu_funct3_o, lsu_addr_o, lsu_wdata_o, lsu_rd_tag_o
  );

endinterface

// File: rtl/agu_operand_slot.sv
// One source-operand register of a queue entry.
// Written on push (value if ready, otherwise producer tag); while not ready it snoops
// the CDB and captures the value on a tag match. A push whose tag matches the
// same-cycle CDB broadcast is written already-ready.
// Ports:
//   clk_i, reset_i          clock, synchronous active-low reset
//   push_i                  entry is being written this cycle
//   push_val/tag/rdy_i      dispatched operand
//   cdb_valid/tag/data_i    result broadcast
//   val_o, rdy_o            registered operand value and ready flag
module agu_operand_slot #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [31:0]      push_val_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             push_rdy_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_data_i,
  output logic [31:0]      val_o,
  output logic             rdy_o
);

  logic [31:0]      val_d, val_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             rdy_d, rdy_q;

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    rdy_d = rdy_q;
    if (push_i) begin
      tag_d = push_tag_i;
      if (push_rdy_i) begin
        val_d = push_val_i;
        rdy_d = 1'b1;
      end else if (cdb_valid_i && (cdb_tag_i == push_tag_i)) begin
        val_d = cdb_data_i;
        rdy_d = 1'b1;
      end else begin
        rdy_d = 1'b0;
      end
    end else if (!rdy_q && cdb_valid_i && (cdb_tag_i == tag_q)) begin
      val_d = cdb_data_i;
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      val_q <= '0;
      tag_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
      rdy_q <= rdy_d;
    end
  end

  assign val_o = val_q;
  assign rdy_o = rdy_q;

endmodule

// File: rtl/lsu_agu_queue.sv
// In-order memory-op queue with address generation, between dispatch and the lsu.
// Ops are pushed at the tail, wait for rs1 (and rs2 for stores) via CDB snooping,
// and only the head is offered to the lsu, so issue follows program order.
// Effective address = (rs1 + imm) truncated to DMEM_ADDR_LEN bits.
// Ports:
//   clk_i    clock
//   reset_i  synchronous reset, active-low
//   flush_i  synchronous clear of all entries
//   bus      lsu_agu_queue_if.slave: dispatch, CDB and lsu-issue signals
// Optional: define LSU_MISALIGN_TRAP_EN to drive bus.lsu_misalign_o.
module lsu_agu_queue
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TAG_W         = 4,
  parameter int unsigned DMEM_ADDR_LEN = 8
) (
  input logic            clk_i,
  input logic            reset_i,
  input logic            flush_i,
  lsu_agu_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [PtrW-1:0]  head_d, head_q, tail_d, tail_q;
  logic [CntW-1:0]  count_d, count_q;
  entry_meta_t      meta_d   [DEPTH];
  entry_meta_t      meta_q   [DEPTH];
  logic [TAG_W-1:0] rd_tag_d [DEPTH];
  logic [TAG_W-1:0] rd_tag_q [DEPTH];

  logic [31:0] rs1_val [DEPTH];
  logic        rs1_rdy [DEPTH];
  logic [31:0] rs2_val [DEPTH];
  logic        rs2_rdy [DEPTH];

  logic        disp_ready, push, pop, lsu_valid;
  entry_meta_t head_meta;
  logic [31:0] ea;
  logic        unused_ea;

  // Deliberately ignores a same-cycle pop: a full queue stalls dispatch for one cycle.
  assign disp_ready = reset_i & ~flush_i & (count_q != Full);
  assign push       = bus.disp_valid_i & disp_ready;
  assign pop        = lsu_valid & bus.lsu_ready_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic push_here;
    assign push_here = push & (tail_q == PtrW'(i));

    agu_operand_slot #(
      .TAG_W(TAG_W)
    ) u_rs1 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .push_i     (push_here),
      .push_val_i (bus.disp_rs1_val_i),
      .push_tag_i (bus.disp_rs1_tag_i),
      .push_rdy_i (bus.disp_rs1_rdy_i),
      .cdb_valid_i(bus.cdb_valid_i),
      .cdb_tag_i  (bus.cdb_tag_i),
      .cdb_data_i (bus.cdb_data_i),
      .val_o      (rs1_val[i]),
      .rdy_o      (rs1_rdy[i])
    );

    // Loads never consume rs2, so it is written ready to keep it from blocking issue.
    agu_operand_slot #(
      .TAG_W(TAG_W)
    ) u_rs2 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .push_i     (push_here),
      .push_val_i (bus.disp_rs2_val_i),
      .push_tag_i (bus.disp_rs2_tag_i),
      .push_rdy_i (bus.disp_rs2_rdy_i | ~bus.disp_is_store_i),
      .cdb_valid_i(bus.cdb_valid_i),
      .cdb_tag_i  (bus.cdb_tag_i),
      .cdb_data_i (bus.cdb_data_i),
      .val_o      (rs2_val[i]),
      .rdy_o      (rs2_rdy[i])
    );
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    meta_d   = meta_q;
    rd_tag_d = rd_tag_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        meta_d[i].valid = 1'b0;
      end
    end else begin
      if (push) begin
        meta_d[tail_q] = '{valid:    1'b1,
                           is_store: bus.disp_is_store_i,
                           funct3:   bus.disp_funct3_i,
                           imm:      bus.disp_imm_i};
        rd_tag_d[tail_q] = bus.disp_rd_tag_i;
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        meta_d[head_q].valid = 1'b0;
        head_d = head_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        meta_q[i]   <= '0;
        rd_tag_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      meta_q   <= meta_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  // Issue side is a pure function of registered state: no path from cdb_* or disp_*.
  assign head_meta = meta_q[head_q];
  assign lsu_valid = head_meta.valid & rs1_rdy[head_q] &
                     (~head_meta.is_store | rs2_rdy[head_q]);
  assign ea        = rs1_val[head_q] + head_meta.imm;
  assign unused_ea = ^ea[31:DMEM_ADDR_LEN];

  assign bus.disp_ready_o   = disp_ready;
  assign bus.lsu_valid_o    = lsu_valid;
  assign bus.lsu_is_store_o = head_meta.is_store;
  assign bus.lsu_funct3_o   = head_meta.funct3;
  assign bus.lsu_addr_o     = ea[DMEM_ADDR_LEN-1:0];
  assign bus.lsu_wdata_o    = rs2_val[head_q];
  assign bus.lsu_rd_tag_o   = rd_tag_q[head_q];

`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.lsu_misalign_o = lsu_valid & is_misaligned(head_meta.funct3, ea[1:0]);
`endif

endmodule

// File: tb/tb_lsu_agu_queue.sv
// Self-checking bench for lsu_agu_queue: a scoreboard of expected issued ops is
// filled as ops are dispatched and drained by a monitor at every lsu handshake;
// scenario tasks also check timing and flow-control signals inline.
module tb_lsu_agu_queue;
  import lsu_pkg::*;

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  always #5 clk = ~clk;

  lsu_agu_queue_if #(.TAG_W(TAG_W), .DMEM_ADDR_LEN(ADDR_W)) bus ();

  lsu_agu_queue #(
    .DEPTH        (DEPTH),
    .TAG_W        (TAG_W),
    .DMEM_ADDR_LEN(ADDR_W)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_n),
    .flush_i(flush),
    .bus    (bus)
  );

  typedef struct {
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [TAG_W-1:0]  rd_tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Scoreboard monitor: every accepted issue must match the oldest expected op.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.lsu_valid_o && bus.lsu_ready_i) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got addr=%h rd=%h, required no issue",
                 bus.lsu_addr_o, bus.lsu_rd_tag_o);
      end else begin
        e = sb.pop_front();
        if ({bus.lsu_is_store_o, bus.lsu_funct3_o, bus.lsu_addr_o, bus.lsu_rd_tag_o} !==
            {e.is_store, e.funct3, e.addr, e.rd_tag}) begin
          n_fail++;
          $display("FAIL issue_op: got st=%b f3=%b addr=%h rd=%h, required st=%b f3=%b addr=%h rd=%h",
                   bus.lsu_is_store_o, bus.lsu_funct3_o, bus.lsu_addr_o, bus.lsu_rd_tag_o,
                   e.is_store, e.funct3, e.addr, e.rd_tag);
        end
        if (e.is_store) begin
          n_cmp++;
          if (bus.lsu_wdata_o !== e.wdata) begin
            n_fail++;
            $display("FAIL issue_wdata: got %h, required %h", bus.lsu_wdata_o, e.wdata);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                        input logic [TAG_W-1:0] rd,
                        input logic [31:0] v1, input logic [TAG_W-1:0] t1, input logic r1,
                        input logic [31:0] v2, input logic [TAG_W-1:0] t2, input logic r2);
    bus.disp_valid_i    = 1'b1;
    bus.disp_is_store_i = st;
    bus.disp_funct3_i   = f3;
    bus.disp_imm_i      = imm;
    bus.disp_rd_tag_i   = rd;
    bus.disp_rs1_val_i  = v1;
    bus.disp_rs1_tag_i  = t1;
    bus.disp_rs1_rdy_i  = r1;
    bus.disp_rs2_val_i  = v2;
    bus.disp_rs2_tag_i  = t2;
    bus.disp_rs2_rdy_i  = r2;
  endtask

  task automatic expect_op(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [31:0] wd,
                           input logic [TAG_W-1:0] rd);
    exp_t        e;
    logic [31:0] sum;
    sum       = rs1 + imm;
    e.is_store = st;
    e.funct3   = f3;
    e.addr     = sum[ADDR_W-1:0];
    e.wdata    = wd;
    e.rd_tag   = rd;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    bus.lsu_ready_i = 1'b1;
    for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d ops still pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    set_op(OP_LOAD, 3'b010, 32'h4, 4'h1, 32'h10, '0, 1'b1, '0, '0, 1'b1);
    bus.lsu_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if (bus.disp_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_disp_ready: got %b, required 0", bus.disp_ready_o);
    end
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lsu_valid: got %b, required 0", bus.lsu_valid_o);
    end
    tick();
    reset_n = 1'b1;
    bus.disp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.disp_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_disp_ready: got %b, required 1", bus.disp_ready_o);
    end
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_lsu_valid: got %b, required 0", bus.lsu_valid_o);
    end
  endtask

  task automatic test_load;
    tick();
    bus.lsu_ready_i = 1'b0;
    set_op(OP_LOAD, 3'b010, 32'h4, 4'h5, 32'h10, '0, 1'b1, '0, '0, 1'b0);
    expect_op(OP_LOAD, 3'b010, 32'h10, 32'h4, '0, 4'h5);
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_same_cycle: got lsu_valid=%b, required 0", bus.lsu_valid_o);
    end
    tick();
    bus.disp_valid_i = 1'b0;
    bus.lsu_ready_i  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_next_cycle: got lsu_valid=%b, required 1", bus.lsu_valid_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_popped: got lsu_valid=%b, required 0", bus.lsu_valid_o);
    end
  endtask

  task automatic test_store_wakeup;
    tick();
    bus.lsu_ready_i = 1'b1;
    set_op(OP_STORE, 3'b010, 32'h0, 4'h0, 32'h20, '0, 1'b1, '0, 4'h3, 1'b0);
    expect_op(OP_STORE, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 4'h0);
    tick();
    bus.disp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL store_waits_rs2: got lsu_valid=%b, required 0", bus.lsu_valid_o);
    end
    tick();
    bus.cdb_valid_i = 1'b1;
    bus.cdb_tag_i   = 4'h3;
    bus.cdb_data_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL store_wake_same_cycle: got lsu_valid=%b, required 0", bus.lsu_valid_o);
    end
    tick();
    bus.cdb_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL store_wake_next_cycle: got lsu_valid=%b, required 1", bus.lsu_valid_o);
    end
    // Dispatch with a waiting rs2 whose producer broadcasts in the same cycle.
    tick();
    set_op(OP_STORE, 3'b001, 32'h2, 4'h0, 32'h30, '0, 1'b1, '0, 4'h7, 1'b0);
    bus.cdb_valid_i = 1'b1;
    bus.cdb_tag_i   = 4'h7;
    bus.cdb_data_i  = 32'h1234_ABCD;
    expect_op(OP_STORE, 3'b001, 32'h30, 32'h2, 32'h1234_ABCD, 4'h0);
    tick();
    bus.disp_valid_i = 1'b0;
    bus.cdb_valid_i  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL push_bypass: got lsu_valid=%b, required 1", bus.lsu_valid_o);
    end
    tick();
  endtask

  task automatic test_full_wrap;
    logic [2:0]  f3s [4];
    logic [31:0] v1, imm;
    f3s = '{3'b000, 3'b100, 3'b101, 3'b001};
    bus.lsu_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      v1  = (i == 0) ? 32'hFFFF_FFF0 : (32'h100 * i + 32'h40);
      imm = (i == 0) ? 32'h20 : 32'hFFFF_FFFC;
      set_op(OP_LOAD, f3s[i], imm, TAG_W'(8 + i), v1, '0, 1'b1, '0, '0, 1'b0);
      expect_op(OP_LOAD, f3s[i], v1, imm, '0, TAG_W'(8 + i));
      @(negedge clk);
      n_cmp++;
      if (bus.disp_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_accept_%0d: got disp_ready=%b, required 1", i, bus.disp_ready_o);
      end
    end
    tick();
    set_op(OP_STORE, 3'b010, 32'h8, 4'hC, 32'h70, '0, 1'b1, 32'hCAFE_F00D, '0, 1'b1);
    bus.lsu_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.disp_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_bypass: got disp_ready=%b, required 0", bus.disp_ready_o);
    end
    tick();
    bus.lsu_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.disp_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_pop: got disp_ready=%b, required 1", bus.disp_ready_o);
    end
    expect_op(OP_STORE, 3'b010, 32'h70, 32'h8, 32'hCAFE_F00D, 4'hC);
    tick();
    bus.disp_valid_i = 1'b0;
    drain("wrap");
  endtask

  task automatic test_in_order;
    tick();
    bus.lsu_ready_i = 1'b1;
    set_op(OP_LOAD, 3'b010, 32'h8, 4'h1, '0, 4'h9, 1'b0, '0, '0, 1'b0);
    expect_op(OP_LOAD, 3'b010, 32'h40, 32'h8, '0, 4'h1);
    tick();
    set_op(OP_LOAD, 3'b100, 32'h0, 4'h2, 32'h80, '0, 1'b1, '0, '0, 1'b0);
    expect_op(OP_LOAD, 3'b100, 32'h80, 32'h0, '0, 4'h2);
    tick();
    bus.disp_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.lsu_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL inorder_blocked_%0d: got lsu_valid=%b, required 0", k, bus.lsu_valid_o);
      end
      tick();
    end
    bus.cdb_valid_i = 1'b1;
    bus.cdb_tag_i   = 4'h9;
    bus.cdb_data_i  = 32'h40;
    tick();
    bus.cdb_valid_i = 1'b0;
    drain("inorder");
  endtask

  task automatic test_flush;
    bus.lsu_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_op(OP_LOAD, 3'b010, 32'h0, TAG_W'(i), 32'h200 + 32'(i), '0, 1'b1, '0, '0, 1'b0);
    end
    tick();
    set_op(OP_LOAD, 3'b010, 32'h0, 4'hF, 32'h300, '0, 1'b1, '0, '0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.disp_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_blocks_push: got disp_ready=%b, required 0", bus.disp_ready_o);
    end
    tick();
    flush = 1'b0;
    bus.disp_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.lsu_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_empty_%0d: got lsu_valid=%b, required 0", k, bus.lsu_valid_o);
      end
      tick();
    end
    set_op(OP_LOAD, 3'b000, 32'h1, 4'hA, 32'h55, '0, 1'b1, '0, '0, 1'b0);
    expect_op(OP_LOAD, 3'b000, 32'h55, 32'h1, '0, 4'hA);
    tick();
    bus.disp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.lsu_valid_o, bus.disp_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL post_flush_issue: got valid,ready=%b%b, required 11",
               bus.lsu_valid_o, bus.disp_ready_o);
    end
    tick();
    drain("flush");
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_misalign;
    logic [2:0] f3s [2];
    logic       req [2];
    f3s = '{3'b010, 3'b001};
    req = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.lsu_ready_i = 1'b0;
      set_op(OP_LOAD, f3s[i], 32'h2, 4'h3, 32'h0, '0, 1'b1, '0, '0, 1'b0);
      tick();
      bus.disp_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.lsu_valid_o, bus.lsu_misalign_o} !== {1'b1, req[i]}) begin
        n_fail++;
        $display("FAIL misalign_%0d: got valid,misalign=%b%b, required 1%b",
                 i, bus.lsu_valid_o, bus.lsu_misalign_o, req[i]);
      end
      tick();
      expect_op(OP_LOAD, f3s[i], 32'h0, 32'h2, '0, 4'h3);
      drain("misalign");
    end
  endtask
`endif

  initial begin
    flush               = 1'b0;
    reset_n             = 1'b0;
    bus.disp_valid_i    = 1'b0;
    bus.disp_is_store_i = 1'b0;
    bus.disp_funct3_i   = '0;
    bus.disp_imm_i      = '0;
    bus.disp_rd_tag_i   = '0;
    bus.disp_rs1_val_i  = '0;
    bus.disp_rs1_tag_i  = '0;
    bus.disp_rs1_rdy_i  = 1'b0;
    bus.disp_rs2_val_i  = '0;
    bus.disp_rs2_tag_i  = '0;
    bus.disp_rs2_rdy_i  = 1'b0;
    bus.cdb_valid_i     = 1'b0;
    bus.cdb_tag_i       = '0;
    bus.cdb_data_i      = '0;
    bus.lsu_ready_i     = 1'b0;

    test_reset();
    test_load();
    test_store_wakeup();
    test_full_wrap();
    test_in_order();
    test_flush();
`ifdef LSU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
